// File: rtl/vga_timing.sv
// 1280x1024@60 raster timing: pixel counters, display enable and frame pulse from next-state counters.
// Pins (HS/VS/BLANK_N) lag the counters by PIPE clocks to line up with registered pixel data.
module vga_timing #(
  parameter int H_VIS  = 1280,
  parameter int H_FP   = 48,
  parameter int H_SYNC = 112,
  parameter int H_BP   = 248,
  parameter int V_VIS  = 1024,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 38,
  parameter int H_POL  = 1,
  parameter int V_POL  = 1,
  parameter int PIPE   = 1
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        disp_en,
  output logic        new_frame,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_STOP  = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_STOP  = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic        H_ACT    = (H_POL != 0);
  localparam logic        V_ACT    = (V_POL != 0);
  // Stage layout is {hsync, vsync, display enable}; idle means syncs inactive and blanked.
  localparam logic [2:0]  IDLE     = {~H_ACT, ~V_ACT, 1'b0};

  generate
    if (H_TOTAL > 2047 || V_TOTAL > 2047 || PIPE < 0 || PIPE > 4) begin : g_bad_cfg
      $error("vga_timing: unsupported timing parameters");
    end
  endgenerate

  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        de_nxt;
  logic [2:0]  stage [0:PIPE];

  always_comb begin
    x_nxt = x + 11'd1;
    y_nxt = y;
    if (x == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y == V_LAST) ? '0 : y + 11'd1;
    end
    de_nxt = (x_nxt < H_VIS_W) && (y_nxt < V_VIS_W);
    hs_nxt = (x_nxt >= HS_START && x_nxt < HS_STOP) ? H_ACT : ~H_ACT;
    vs_nxt = (y_nxt >= VS_START && y_nxt < VS_STOP) ? V_ACT : ~V_ACT;
  end

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      x         <= H_LAST;
      y         <= V_LAST;
      new_frame <= 1'b0;
      for (int i = 0; i <= PIPE; i++) begin
        stage[i] <= IDLE;
      end
    end else begin
      x         <= x_nxt;
      y         <= y_nxt;
      new_frame <= (x_nxt == 11'd0) && (y_nxt == 11'd0);
      stage[0]  <= {hs_nxt, vs_nxt, de_nxt};
      for (int i = 1; i <= PIPE; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign disp_en                            = stage[0][0];
  assign {VGA_HS, VGA_VS, VGA_BLANK_N}      = stage[PIPE];
  assign VGA_SYNC_N                         = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one full-size instance plus three small-raster instances (PIPE 0/2/4),
// all compared each clock against a time-indexed arithmetic model of the raster.
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        nf;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
  } obs_t;

  typedef struct packed {
    int hv; int hfp; int hsw; int hbp;
    int vv; int vfp; int vsw; int vbp;
    int hpol; int vpol; int pipe;
  } cfg_t;

  localparam cfg_t C_F = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1, 1, 1};
  localparam cfg_t C_A = '{16, 4, 6, 6, 10, 1, 3, 2, 0, 0, 0};
  localparam cfg_t C_B = '{16, 4, 6, 6, 10, 1, 3, 2, 1, 1, 2};
  localparam cfg_t C_C = '{16, 4, 6, 6, 10, 1, 3, 2, 1, 0, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f;
  logic rst_s;

  logic [10:0] f_x, f_y, a_x, a_y, b_x, b_y, c_x, c_y;
  logic f_de, f_nf, f_hs, f_vs, f_bn, f_sn;
  logic a_de, a_nf, a_hs, a_vs, a_bn, a_sn;
  logic b_de, b_nf, b_hs, b_vs, b_bn, b_sn;
  logic c_de, c_nf, c_hs, c_vs, c_bn, c_sn;
  obs_t f_o, a_o, b_o, c_o;

  assign f_o = {f_x, f_y, f_de, f_nf, f_hs, f_vs, f_bn, f_sn};
  assign a_o = {a_x, a_y, a_de, a_nf, a_hs, a_vs, a_bn, a_sn};
  assign b_o = {b_x, b_y, b_de, b_nf, b_hs, b_vs, b_bn, b_sn};
  assign c_o = {c_x, c_y, c_de, c_nf, c_hs, c_vs, c_bn, c_sn};

  vga_timing #(.H_VIS(C_F.hv), .H_FP(C_F.hfp), .H_SYNC(C_F.hsw), .H_BP(C_F.hbp),
               .V_VIS(C_F.vv), .V_FP(C_F.vfp), .V_SYNC(C_F.vsw), .V_BP(C_F.vbp),
               .H_POL(C_F.hpol), .V_POL(C_F.vpol), .PIPE(C_F.pipe)) u_full (
    .VGA_CLK(clk), .reset(rst_f), .x(f_x), .y(f_y), .disp_en(f_de), .new_frame(f_nf),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_bn), .VGA_SYNC_N(f_sn));

  vga_timing #(.H_VIS(C_A.hv), .H_FP(C_A.hfp), .H_SYNC(C_A.hsw), .H_BP(C_A.hbp),
               .V_VIS(C_A.vv), .V_FP(C_A.vfp), .V_SYNC(C_A.vsw), .V_BP(C_A.vbp),
               .H_POL(C_A.hpol), .V_POL(C_A.vpol), .PIPE(C_A.pipe)) u_p0 (
    .VGA_CLK(clk), .reset(rst_s), .x(a_x), .y(a_y), .disp_en(a_de), .new_frame(a_nf),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn));

  vga_timing #(.H_VIS(C_B.hv), .H_FP(C_B.hfp), .H_SYNC(C_B.hsw), .H_BP(C_B.hbp),
               .V_VIS(C_B.vv), .V_FP(C_B.vfp), .V_SYNC(C_B.vsw), .V_BP(C_B.vbp),
               .H_POL(C_B.hpol), .V_POL(C_B.vpol), .PIPE(C_B.pipe)) u_p2 (
    .VGA_CLK(clk), .reset(rst_s), .x(b_x), .y(b_y), .disp_en(b_de), .new_frame(b_nf),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn));

  vga_timing #(.H_VIS(C_C.hv), .H_FP(C_C.hfp), .H_SYNC(C_C.hsw), .H_BP(C_C.hbp),
               .V_VIS(C_C.vv), .V_FP(C_C.vfp), .V_SYNC(C_C.vsw), .V_BP(C_C.vbp),
               .H_POL(C_C.hpol), .V_POL(C_C.vpol), .PIPE(C_C.pipe)) u_p4 (
    .VGA_CLK(clk), .reset(rst_s), .x(c_x), .y(c_y), .disp_en(c_de), .new_frame(c_nf),
    .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_BLANK_N(c_bn), .VGA_SYNC_N(c_sn));

  int   nchk = 0;
  int   nerr = 0;
  int   tf = 0;   // rising edges seen by u_full since its reset last released
  int   ts = 0;   // same for the small instances
  bit   win = 1'b1;
  int   de_cnt = 0, nf_cnt = 0, nf_first = 0, nf_last = 0, vs_b = 0, vs_c = 0;
  logic prev_hs = 1'b0;

  // Raster position is (t-1) mod frame length; pins show the raw raster PIPE edges earlier.
  function automatic obs_t model(input cfg_t c, input int t);
    int ht, vt, ft, p, q, qx, qy;
    obs_t o;
    ht = c.hv + c.hfp + c.hsw + c.hbp;
    vt = c.vv + c.vfp + c.vsw + c.vbp;
    ft = ht * vt;
    o  = '0;
    if (t < 1) begin
      o.x = 11'(ht - 1);
      o.y = 11'(vt - 1);
    end else begin
      p    = (t - 1) % ft;
      o.x  = 11'(p % ht);
      o.y  = 11'(p / ht);
      o.de = (p % ht < c.hv) && (p / ht < c.vv);
      o.nf = (p == 0);
    end
    if (t - c.pipe < 1) begin
      o.hs = (c.hpol == 0);
      o.vs = (c.vpol == 0);
      o.bn = 1'b0;
    end else begin
      q    = (t - c.pipe - 1) % ft;
      qx   = q % ht;
      qy   = q / ht;
      o.hs = ((qx >= c.hv + c.hfp) && (qx < c.hv + c.hfp + c.hsw)) == (c.hpol != 0);
      o.vs = ((qy >= c.vv + c.vfp) && (qy < c.vv + c.vfp + c.vsw)) == (c.vpol != 0);
      o.bn = (qx < c.hv) && (qy < c.vv);
    end
    return o;
  endfunction

  task automatic chk_o(input string tag, input obs_t got, input obs_t exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk_o($sformatf("full t=%0d", tf), f_o, model(C_F, tf));
    chk_o($sformatf("pipe0 t=%0d", ts), a_o, model(C_A, ts));
    chk_o($sformatf("pipe2 t=%0d", ts), b_o, model(C_B, ts));
    chk_o($sformatf("pipe4 t=%0d", ts), c_o, model(C_C, ts));
  endtask

  task automatic tick();
    obs_t fm;
    @(posedge clk);
    if (rst_f) tf++;
    if (rst_s) ts++;
    #1;
    check_all();
    fm = model(C_F, tf);
    if (tf >= 1 && fm.y == 11'd0 && fm.x == 11'd1329)
      chk_v("hs_rise_at_1329", 32'({prev_hs, f_hs}), 32'd1);
    prev_hs = f_hs;
    if (win) begin
      if (tf >= 1 && tf <= 1688 && f_de) de_cnt++;
      if (ts >= 1 && ts <= 1024 && a_nf) begin
        if (nf_cnt == 0) nf_first = ts;
        nf_last = ts;
        nf_cnt++;
      end
      if (ts >= 5 && ts <= 516) begin
        if (b_vs == 1'b1) vs_b++;
        if (c_vs == 1'b0) vs_c++;
      end
    end
  endtask

  initial begin
    rst_f = 1'b0;
    rst_s = 1'b0;
    repeat (10) tick();
    chk_o("full_reset_values", f_o, obs_t'{x: 11'd1687, y: 11'd1065, default: 1'b0});

    #1;
    rst_f = 1'b1;
    rst_s = 1'b1;
    tick();
    chk_v("first_edge_full", 32'({f_x, f_y, f_de, f_nf}), 32'({11'd0, 11'd0, 1'b1, 1'b1}));
    chk_v("first_edge_small", 32'({a_x, a_y, a_de, a_nf}), 32'({11'd0, 11'd0, 1'b1, 1'b1}));

    while (tf < 1689) tick();
    chk_v("line0_de_clocks", 32'(de_cnt), 32'd1280);
    chk_v("nf_per_2frames", 32'(nf_cnt), 32'd2);
    chk_v("nf_period", 32'(nf_last - nf_first), 32'd512);
    chk_v("vs_clocks_pipe2", 32'(vs_b), 32'd96);
    chk_v("vs_clocks_pipe4", 32'(vs_c), 32'd96);
    win = 1'b0;

    // Mid-frame reset of the full-size raster at (500,1)
    while (tf < 2189) tick();
    chk_v("full_pos_before_reset", 32'({f_x, f_y}), 32'({11'd500, 11'd1}));
    #1;
    rst_f = 1'b0;
    tf    = 0;
    #1;
    chk_o("full_async_reset", f_o, obs_t'{x: 11'd1687, y: 11'd1065, default: 1'b0});
    repeat (3) tick();
    #1;
    rst_f = 1'b1;
    tick();
    chk_v("full_restart", 32'({f_x, f_y, f_de, f_nf}), 32'({11'd0, 11'd0, 1'b1, 1'b1}));
    repeat ($urandom_range(1700, 2200)) tick();

    // Small rasters: reset at a random point, 3 clocks
    repeat ($urandom_range(40, 500)) tick();
    #1;
    rst_s = 1'b0;
    ts    = 0;
    #1;
    check_all();
    repeat (3) tick();
    #1;
    rst_s = 1'b1;
    tick();
    chk_v("small_restart", 32'({a_x, a_y, a_de, a_nf}), 32'({11'd0, 11'd0, 1'b1, 1'b1}));
    repeat (1100) tick();

    // Small rasters: reset at a random point with a random hold
    repeat ($urandom_range(10, 300)) tick();
    #1;
    rst_s = 1'b0;
    ts    = 0;
    #1;
    check_all();
    repeat ($urandom_range(1, 6)) tick();
    #1;
    rst_s = 1'b1;
    repeat (600) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
